// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port: FSM states,
// funct3 access-size codes and access classification helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte and half accesses; every unlisted code behaves as a word.
    function automatic logic is_subword(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU) || (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            default:     return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction with sign/zero
// extension, and byte/half lane merge of store data into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    input  logic [31:0] base,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Halves use only off[1], so an odd half address folds onto its even lane.
    assign byte_val = rd_word[{off, 3'b000} +: 8];
    assign half_val = rd_word[{off[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        load_data  = rd_word;
        store_word = wdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'h0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'h0, half_val};
            default: ;
        endcase
        case (funct3)
            F3_B, F3_BU: begin
                store_word = base;
                store_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H, F3_HU: begin
                store_word = base;
                store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store port onto a word-wide memory with read-modify-write
// for byte/half stores. Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            done,
    output logic            misaligned,
    output logic [XLEN-1:0] mem_A,
    output logic [XLEN-1:0] mem_WD,
    output logic            mem_WE,
    input  logic [XLEN-1:0] mem_RD
);

    state_t          state, state_next;
    logic [XLEN-1:0] addr_q, wdata_q, merge_q;
    logic [XLEN-1:0] load_data, store_word, word_addr;
    logic [2:0]      funct3_q;
    logic            we_q, write_en, accept, mis_hit;

    assign accept    = (state == IDLE) && req;
    assign word_addr = {addr_q[XLEN-1:2], 2'b00};

    lsu_align u_align (
        .funct3     (funct3_q),
        .off        (addr_q[1:0]),
        .rd_word    (mem_RD),
        .base       (merge_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned_q;

    assign mis_hit = is_misaligned(funct3, addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst)         misaligned_q <= 1'b0;
        else if (accept) misaligned_q <= mis_hit;
    end

    assign misaligned = misaligned_q;
`else
    assign mis_hit    = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
                we_q     <= we;
                if (mis_hit) rdata <= '0;
            end
            if (state == ACCESS && !we_q) rdata   <= load_data;
            if (state == ACCESS && we_q)  merge_q <= mem_RD;
        end
    end

    always_comb begin
        state_next = state;
        write_en   = 1'b0;
        done       = 1'b0;
        mem_A      = '0;
        mem_WD     = '0;
        case (state)
            IDLE: begin
                if (req) state_next = mis_hit ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_A = word_addr;
                if (we_q && !is_subword(funct3_q)) begin
                    write_en   = 1'b1;
                    mem_WD     = wdata_q;
                    state_next = DONE;
                end else if (we_q) begin
                    state_next = WRITE;
                end else begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                mem_A      = word_addr;
                mem_WD     = store_word;
                write_en   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst so a reset landing in WRITE cannot commit a partial store.
    assign mem_WE = write_en & ~rst;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases plus random loads/stores
// checked against a byte-addressed reference memory.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, mem_A, mem_WD, mem_RD;
    logic        done, misaligned, mem_WE;

    always #5 clk = ~clk;

    lsu_mem_port #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .misaligned (misaligned),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    // Word memory seen by the DUT; preloaded through the same write process.
    logic [31:0] ram [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          we_count = 0;
    logic [31:0] we_addr = '0;

    assign mem_RD = ram[mem_A[11:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end else if (mem_WE) begin
            ram[mem_A[11:2]] <= mem_WD;
            we_count         <= we_count + 1;
            we_addr          <= mem_A;
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Reference behaviour of one access; updates ref_mem / exp_rdata.
    task automatic ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic mis,
                          output int nwrites, output logic [31:0] ea);
        int          sz;
        logic [31:0] val;
        sz      = size_of(f3);
        mis     = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis     = (a % sz) != 0;
`endif
        ea      = a - (a % sz);
        nwrites = 0;
        if (mis) begin
            lat       = 1;
            exp_rdata = 32'h0;
        end else if (w) begin
            for (int k = 0; k < sz; k++) ref_mem[ea + k] = d[8*k +: 8];
            lat     = (sz == 4) ? 2 : 3;
            nwrites = 1;
        end else begin
            val = 32'h0;
            for (int k = 0; k < sz; k++) val = val | (32'(ref_mem[ea + k]) << (8 * k));
            if (f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
            if (f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
            exp_rdata = val;
            lat       = 2;
        end
    endtask

    // Issues one request; returns edges from accept until done and done one edge later.
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic mis_o,
                          output logic done_after);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        mis_o = misaligned;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic checked_op(input string tag, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
        int          exp_lat, lat, nw, wc0;
        logic        exp_mis, mis_o, done_after;
        logic [31:0] ea;
        wc0 = we_count;
        ref_op(w, f3, a, d, exp_lat, exp_mis, nw, ea);
        run_op(w, f3, a, d, lat, mis_o, done_after);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_misaligned"}, {31'h0, mis_o}, {31'h0, exp_mis});
        check({tag, "_done_width"}, {31'h0, done_after}, 32'h0);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_writes"}, we_count - wc0, nw);
        if (nw != 0) check({tag, "_write_addr"}, we_addr, {ea[31:2], 2'b00});
    endtask

    initial begin
        logic [31:0] word;
        logic [2:0]  f3;
        logic        w;
        int          wc0, first, second, pulses, bad;
        int          lat_unused, nw_unused;
        logic        mis_unused;
        logic [31:0] ea_unused;

        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
        exp_rdata = 32'h0;

        for (int i = 0; i < 1024; i++) begin
            word = (i == 500) ? 32'h8CDE_FAB7 : $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = word[8*k +: 8];
            @(negedge clk);
            pre_we = 1'b1; pre_idx = 10'(i); pre_data = word;
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_misaligned", {31'h0, misaligned}, 32'h0);
        check("reset_mem_we", {31'h0, mem_WE}, 32'h0);
        check("reset_mem_a", mem_A, 32'h0);
        rst = 1'b0;

        // Directed loads on the preloaded word 0x8CDEFAB7 @ 0x7D0
        checked_op("lb_7d1", 1'b0, 3'b000, 32'h7D1, 32'h0);
        check("lb_7d1_value", rdata, 32'hFFFF_FFFA);
        checked_op("lbu_7d1", 1'b0, 3'b100, 32'h7D1, 32'h0);
        check("lbu_7d1_value", rdata, 32'h0000_00FA);
        checked_op("lh_7d2", 1'b0, 3'b001, 32'h7D2, 32'h0);
        check("lh_7d2_value", rdata, 32'hFFFF_8CDE);
        checked_op("lhu_7d2", 1'b0, 3'b101, 32'h7D2, 32'h0);
        check("lhu_7d2_value", rdata, 32'h0000_8CDE);
        checked_op("lw_7d2", 1'b0, 3'b010, 32'h7D2, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("lw_7d2_value", rdata, 32'h0);
`else
        check("lw_7d2_value", rdata, 32'h8CDE_FAB7);
`endif

        // sh aborted by reset while in WRITE
        wc0 = we_count;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h7D0; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_mem_we_gated", {31'h0, mem_WE}, 32'h0);
        check("abort_no_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 32'h0;
        check("abort_rdata", rdata, 32'h0);
        check("abort_done_after", {31'h0, done}, 32'h0);
        check("abort_no_write", we_count - wc0, 0);
        check("abort_mem_word", ram[500], 32'h8CDE_FAB7);
        checked_op("lw_after_abort", 1'b0, 3'b010, 32'h7D0, 32'h0);
        check("lw_after_abort_value", rdata, 32'h8CDE_FAB7);

        // Stores
        checked_op("sb_7d3", 1'b1, 3'b000, 32'h7D3, 32'h0000_0011);
        check("sb_7d3_word", ram[500], 32'h11DE_FAB7);
        checked_op("sw_7d4", 1'b1, 3'b010, 32'h7D4, 32'hDEAD_BEEF);
        check("sw_7d4_addr", we_addr, 32'h0000_07D4);
        check("sw_7d4_word", ram[501], 32'hDEAD_BEEF);

        // req held high: busy cycles and the DONE cycle must not accept
        ref_op(1'b0, 3'b010, 32'h7D4, 32'h0, lat_unused, mis_unused, nw_unused, ea_unused);
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h7D4; wdata = 32'h0;
        @(posedge clk); #1;
        first = 0; second = 0; pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            if (done) begin
                pulses++;
                if (first == 0) first = e;
                else if (second == 0) second = e;
            end
            if (e < 8) begin
                @(posedge clk); #1;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("b2b_first_done", first, 2);
        check("b2b_second_done", second, 5);
        check("b2b_pulses", pulses, 3);
        check("b2b_rdata", rdata, exp_rdata);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            checked_op($sformatf("rnd%0d", i), w, f3, 32'($urandom_range(0, 4095)), $urandom);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (ram[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) bad++;
        check("mem_sweep_bad_words", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter line: XLEN, 32, data/address width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  1  core access request, sampled only in IDLE.
REQ-005 Port: we  input  1  1 = store, 0 = load.
REQ-006 Port: funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu; other codes are treated as w.
REQ-007 Port: addr  input  XLEN  byte address.
REQ-008 Port: wdata  input  XLEN  store data, right-aligned.
REQ-009 Port: rdata  output  XLEN  load result, registered, held until the next accepted req.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: misaligned  output  1  valid with done.
REQ-012 Port: mem_A  output  XLEN  word-aligned memory address, with bits [1:0] = 00.
REQ-013 Port: mem_WD  output  XLEN  memory write word.
REQ-014 Port: mem_WE  output  1  memory write enable; memory writes on the rising clk edge.
REQ-015 Port: mem_RD  input  XLEN  memory read word; combinational from mem_A.

Function
REQ-016 FSM states: IDLE, ACCESS, WRITE, DONE.
REQ-017 IDLE: on a clk edge with req=1, latch addr, funct3, wdata and we, then go to ACCESS.
REQ-018 ACCESS, load: register the extracted byte/half/word of mem_RD into rdata, then go to DONE.
REQ-019 Load extraction is little-endian: b/h are sign-extended, bu/hu are zero-extended.
REQ-020 ACCESS, sw: assert mem_WE=1 with mem_WD=wdata for one cycle, then go to DONE.
REQ-021 ACCESS, sb/sh: register mem_RD as the merge base, then go to WRITE.
REQ-022 WRITE: assert mem_WE=1 with mem_WD = merge base with the addressed byte/half lanes replaced by wdata[7:0] or wdata[15:0], then go to DONE.
REQ-023 DONE: assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 Latency, counted from the edge that accepts req: loads and sw give done high after the 2nd edge; sb/sh give done high after the 3rd edge.
REQ-025 req asserted outside IDLE is ignored, not queued.
REQ-026 back-to-back operation: req held high in the DONE cycle is not accepted; the next request is accepted at the first edge in IDLE.
REQ-027 In IDLE and DONE: mem_WE=0 and mem_A=0.
REQ-028 During ACCESS and WRITE: mem_A equals the latched addr with bits [1:0] cleared.
REQ-029 mem_WE shall be exactly one pulse per store, combinationally gated low while rst=1.

Reset
REQ-030 With rst=1 at an edge: state = IDLE, rdata=0, done=0, misaligned=0, and all latched fields = 0.
REQ-031 Reset mid-operation (ACCESS or WRITE): the access is aborted, no memory write occurs, and done is not pulsed.

Configuration
REQ-032 Macro LSU_MISALIGN_CHECK_EN defined: misaligned accesses are w with addr[1:0]≠0, and h/hu with addr[0]=1.
REQ-033 With LSU_MISALIGN_CHECK_EN defined, a misaligned access goes IDLE→DONE directly, with no memory access, mem_WE=0, rdata=0 and misaligned=1 with done.
REQ-034 Macro LSU_MISALIGN_CHECK_EN undefined: the misaligned output is tied 0.
REQ-035 With LSU_MISALIGN_CHECK_EN undefined, offending low address bits are ignored: w uses addr[1:0]=00 and h uses addr[0]=0.

Structure
REQ-036 The shared package lsu_pkg holds the state encodings and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-037 One combinational sub-module, lsu_align, performs load extraction/extension and store lane merge from (funct3, addr[1:0]).

Verification
REQ-038 Word 0x8CDEFAB7 preloaded at 0x7D0; lb 0x7D1 -> rdata 0xFFFFFFFA; lbu 0x7D1 -> 0x000000FA; done high 2 edges after accept.
REQ-039 Same word; lh 0x7D2 -> 0xFFFF8CDE; lhu 0x7D2 -> 0x00008CDE.
REQ-040 sb 0x7D3, wdata 0x00000011 -> exactly one mem_WE pulse, memory word 0x11DEFAB7, done 3 edges after accept.
REQ-041 sw 0x7D4, wdata 0xDEADBEEF -> one mem_WE pulse in ACCESS with mem_A=0x7D4, done 2 edges after accept.
REQ-042 lw 0x7D2: with LSU_MISALIGN_CHECK_EN -> misaligned=1, rdata=0, no mem_WE, done 1 edge after accept; without -> rdata 0x8CDEFAB7.
REQ-043 sh 0x7D0, rst=1 during WRITE -> memory still 0x8CDEFAB7, no done pulse, IDLE next cycle; a following lw returns 0x8CDEFAB7.
